axis_fmcw_ramp_source: RTL and testbench
========================================

# axis_fmcw_ramp_source

Upstream companion to the FMCW window block: it takes a free-running ADC IQ sample stream, optionally decimates it, re-times it onto an AXI4-Stream master with backpressure, and emits the one-cycle `ramp` strobe that marks the first sample of every chirp. It sits between the ADC capture logic and the window/FFT chain and is the single source of sweep timing, so downstream `ramp` and sample data are guaranteed aligned.

## Interface
- `DATA_WIDTH`, 48, sample width, {Q, I} packed with Q in upper half
- `PERIOD_WIDTH`, 16, width of samples-per-ramp field
- `aclk`  in  1  clock
- `aresetn`  in  1  reset; asynchronous, active-low
- `cfg_data`  in  32  [15:0] P = samples per ramp; [23:16] D = decimation (keep 1 of D+1); [24] enable; [25] pattern select (see Configuration); [31:26] reserved
- `sts_data`  out  16  completed-ramp counter, wraps
- `err_overrun`  out  1  sticky: sample dropped due to backpressure
- `ramp`  out  1  one-cycle strobe, first sample of a sweep
- `adc_tdata`  in  DATA_WIDTH  ADC sample
- `adc_tvalid`  in  1  ADC sample strobe; no backpressure possible
- `m_axis_data_tdata`  out  DATA_WIDTH  output sample
- `m_axis_data_tvalid`  out  1  output valid
- `m_axis_data_tready`  in  1  downstream ready

## Operation
- Decimator counter d: on each `adc_tvalid` while enabled, sample is *kept* when d==0; d increments, wraps after D (D=0 keeps every sample).
- Sample index k (PERIOD_WIDTH bits): increments on every kept sample, wraps to 0 after P-1; P=0 treated as P=1.
- Kept sample loads the single output register; if k==0 at that sample, `ramp` asserts for exactly the cycle in which that sample first presents `m_axis_data_tvalid`.
- On k wrapping P-1→0, `sts_data` increments.
- Output register: load when kept sample arrives and (register empty, or `m_axis_data_tready` high this cycle). Kept sample arriving while `tvalid`=1 and `tready`=0: sample dropped, register unchanged, `err_overrun` set, k and d still advance (sweep timing stays locked to ADC), `ramp` not asserted for a dropped k==0 sample.
- Holding register obeys AXIS: once `tvalid` is high, `tdata` stable until handshake.
- enable 1→0: d, k cleared; no new samples; a pending output still drains; `err_overrun` cleared; `sts_data` held.
- enable 0→1: next `adc_tvalid` is kept, k=0, so it carries `ramp`.
- cfg P/D changes while enabled take effect at next wrap of the respective counter.

## Timing
- Reset values: `m_axis_data_tvalid`=0, `m_axis_data_tdata`=0, `ramp`=0, `err_overrun`=0, `sts_data`=0; d=k=0.
- Latency: kept `adc_tvalid` in cycle N → `m_axis_data_tvalid` (and `ramp` if k==0) in cycle N+1.
- Simultaneous handshake and new kept sample: register reloads, `tvalid` stays high, no drop.
- `adc_tvalid` on consecutive cycles with `tready` held high: one output per cycle, no drops.
- Reset mid-sweep: all state cleared immediately; first sample after release (with enable) starts a new sweep.

## Configuration
- `FMCW_SRC_TEST_PATTERN_EN` defined: `cfg_data[25]`=1 replaces `adc_tdata` with internal pattern {q, i}, each a DATA_WIDTH/2 counter incrementing by 1 on every `adc_tvalid` (kept or not), reset to 0 on reset and on enable 0→1; timing unchanged.
- Not defined: `cfg_data[25]` ignored, pattern logic absent, `adc_tdata` always used.

## Test plan
- P=4, D=0, enable, `tready`=1, `adc_tvalid` every 64 cycles → outputs 1 cycle after each strobe; `ramp` on samples 0,4,8,…; `sts_data`=2 after 8 samples.
- P=4, D=2, `adc_tvalid` every cycle → output every 3rd strobe; `ramp` every 12 ADC strobes; `err_overrun`=0.
- P=8, `tready`=0 for 3 sample strobes → first sample held stable, next two dropped, `err_overrun`=1; after `tready`=1 next `ramp` still lands exactly 8 kept samples after the previous one.
- Disable at k=5 with pending output, then re-enable → pending sample drains, `err_overrun` cleared, first new sample has `ramp`=1, `sts_data` unchanged.
- `aresetn` low mid-sweep with `tvalid`=1 → all outputs 0 same cycle; post-release first kept sample carries `ramp`.
- With `FMCW_SRC_TEST_PATTERN_EN`, bit25=1, P=10 → `tdata` = {n, n} for n=0,1,2,…; `ramp` on n=0,10,20.

Source files
------------

// File: rtl/axis_fmcw_ramp_source.sv
// ADC IQ stream -> decimate -> AXIS master with chirp-start ramp strobe; `FMCW_SRC_TEST_PATTERN_EN adds {q,i} counter pattern.
// Latency: kept ADC sample in cycle N appears on m_axis_data (with ramp if first of sweep) in cycle N+1.
// Backpressure: single holding register; kept samples arriving while it is stalled are dropped and flag err_overrun.
module axis_fmcw_ramp_source #(
    parameter int DATA_WIDTH   = 48,
    parameter int PERIOD_WIDTH = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [31:0]           cfg_data,
    output logic [15:0]           sts_data,
    output logic                  err_overrun,
    output logic                  ramp,
    input  logic [DATA_WIDTH-1:0] adc_tdata,
    input  logic                  adc_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_data_tdata,
    output logic                  m_axis_data_tvalid,
    input  logic                  m_axis_data_tready
);
    localparam int HALF_WIDTH = DATA_WIDTH / 2;

    logic                    enable;
    logic [7:0]              cfg_d;
    logic [PERIOD_WIDTH-1:0] cfg_p;
    logic                    unused_cfg;

    assign enable     = cfg_data[24];
    assign cfg_d      = cfg_data[23:16];
    assign cfg_p      = cfg_data[PERIOD_WIDTH-1:0];
    assign unused_cfg = ^cfg_data[31:25];

    logic [7:0]              d_cnt;
    logic [7:0]              d_lim;
    logic [7:0]              d_eff;
    logic [PERIOD_WIDTH-1:0] k_cnt;
    logic [PERIOD_WIDTH-1:0] p_lim;
    logic [PERIOD_WIDTH-1:0] p_eff;
    logic [PERIOD_WIDTH-1:0] p_cfg;
    logic                    keep;
    logic                    d_wrap;
    logic                    k_wrap;
    logic                    load;
    logic                    drop;
    logic [DATA_WIDTH-1:0]   sample;

    // Limits are sampled from cfg only at the start of each counter cycle,
    // so reconfiguration while running lands on the next wrap.
    always_comb begin
        p_cfg  = (cfg_p == '0) ? PERIOD_WIDTH'(1) : cfg_p;
        d_eff  = (d_cnt == '0) ? cfg_d : d_lim;
        p_eff  = (k_cnt == '0) ? p_cfg : p_lim;
        keep   = enable && adc_tvalid && (d_cnt == '0);
        d_wrap = (d_cnt == d_eff);
        k_wrap = (k_cnt == p_eff - PERIOD_WIDTH'(1));
        load   = keep && (!m_axis_data_tvalid || m_axis_data_tready);
        drop   = keep && m_axis_data_tvalid && !m_axis_data_tready;
    end

`ifdef FMCW_SRC_TEST_PATTERN_EN
    logic [HALF_WIDTH-1:0] pat_cnt;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pat_cnt <= '0;
        end else if (!enable) begin
            pat_cnt <= '0;
        end else if (adc_tvalid) begin
            pat_cnt <= pat_cnt + HALF_WIDTH'(1);
        end
    end

    assign sample = cfg_data[25] ? {pat_cnt, pat_cnt} : adc_tdata;
`else
    assign sample = adc_tdata;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            d_cnt              <= '0;
            d_lim              <= '0;
            k_cnt              <= '0;
            p_lim              <= '0;
            sts_data           <= '0;
            err_overrun        <= 1'b0;
            ramp               <= 1'b0;
            m_axis_data_tdata  <= '0;
            m_axis_data_tvalid <= 1'b0;
        end else begin
            if (!enable) begin
                d_cnt       <= '0;
                k_cnt       <= '0;
                err_overrun <= 1'b0;
            end else if (adc_tvalid) begin
                if (d_cnt == '0) begin
                    d_lim <= cfg_d;
                end
                d_cnt <= d_wrap ? '0 : d_cnt + 8'd1;
                // Sweep position advances even for dropped samples to stay locked to the ADC.
                if (keep) begin
                    if (k_cnt == '0) begin
                        p_lim <= p_cfg;
                    end
                    k_cnt <= k_wrap ? '0 : k_cnt + PERIOD_WIDTH'(1);
                    if (k_wrap) begin
                        sts_data <= sts_data + 16'd1;
                    end
                end
                if (drop) begin
                    err_overrun <= 1'b1;
                end
            end

            if (load) begin
                m_axis_data_tdata  <= sample;
                m_axis_data_tvalid <= 1'b1;
            end else if (m_axis_data_tready) begin
                m_axis_data_tvalid <= 1'b0;
            end
            ramp <= load && (k_cnt == '0);
        end
    end
endmodule

// File: tb/tb_axis_fmcw_ramp_source.sv
// Directed self-checking bench for axis_fmcw_ramp_source; inputs change and outputs are checked at negedge.
module tb_axis_fmcw_ramp_source;
    logic        aclk;
    logic        aresetn;
    logic [31:0] cfg_data;
    logic [15:0] sts_data;
    logic        err_overrun;
    logic        ramp;
    logic [47:0] adc_tdata;
    logic        adc_tvalid;
    logic [47:0] m_axis_data_tdata;
    logic        m_axis_data_tvalid;
    logic        m_axis_data_tready;

    int checks = 0;
    int errors = 0;

    axis_fmcw_ramp_source #(.DATA_WIDTH(48), .PERIOD_WIDTH(16)) dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .cfg_data           (cfg_data),
        .sts_data           (sts_data),
        .err_overrun        (err_overrun),
        .ramp               (ramp),
        .adc_tdata          (adc_tdata),
        .adc_tvalid         (adc_tvalid),
        .m_axis_data_tdata  (m_axis_data_tdata),
        .m_axis_data_tvalid (m_axis_data_tvalid),
        .m_axis_data_tready (m_axis_data_tready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk_cfg(input logic en, input logic pat,
                                           input logic [7:0] d, input logic [15:0] p);
        return {6'd0, pat, en, d, p};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [47:0] dat);
        adc_tvalid = v;
        adc_tdata  = dat;
        @(negedge aclk);
        adc_tvalid = 1'b0;
    endtask

    initial begin
        aresetn            = 1'b0;
        cfg_data           = '0;
        adc_tdata          = '0;
        adc_tvalid         = 1'b0;
        m_axis_data_tready = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        chk("rst_tvalid", m_axis_data_tvalid, 0);
        chk("rst_tdata", m_axis_data_tdata, 0);
        chk("rst_ramp", ramp, 0);
        chk("rst_err", err_overrun, 0);
        chk("rst_sts", sts_data, 0);
        aresetn = 1'b1;

        // P=4, D=0, sparse strobes
        cfg_data = mk_cfg(1, 0, 8'd0, 16'd4);
        step(0, 0);
        for (int n = 0; n < 8; n++) begin
            step(1, 48'hA0_0000 + 48'(n));
            chk("t1_tvalid", m_axis_data_tvalid, 1);
            chk("t1_tdata", m_axis_data_tdata, 48'hA0_0000 + 48'(n));
            chk("t1_ramp", ramp, (n % 4 == 0) ? 1 : 0);
            step(0, 0);
            chk("t1_drain", m_axis_data_tvalid, 0);
            chk("t1_ramp_low", ramp, 0);
            for (int i = 0; i < 62; i++) step(0, 0);
        end
        chk("t1_sts", sts_data, 2);

        // P=4, D=2, strobes every cycle
        cfg_data = mk_cfg(0, 0, 8'd0, 16'd4);
        step(0, 0);
        cfg_data = mk_cfg(1, 0, 8'd2, 16'd4);
        for (int j = 0; j < 24; j++) begin
            step(1, 48'hB0_0000 + 48'(j));
            chk("t2_tvalid", m_axis_data_tvalid, (j % 3 == 0) ? 1 : 0);
            chk("t2_ramp", ramp, (j % 12 == 0) ? 1 : 0);
            if (j % 3 == 0) chk("t2_tdata", m_axis_data_tdata, 48'hB0_0000 + 48'(j));
        end
        chk("t2_err", err_overrun, 0);
        chk("t2_sts", sts_data, 4);

        // P=8 with a 3-strobe stall
        cfg_data = mk_cfg(0, 0, 8'd0, 16'd8);
        step(0, 0);
        cfg_data = mk_cfg(1, 0, 8'd0, 16'd8);
        step(0, 0);
        m_axis_data_tready = 1'b0;
        step(1, 48'hC0_0000);
        chk("t3_s0_ramp", ramp, 1);
        chk("t3_s0_tdata", m_axis_data_tdata, 48'hC0_0000);
        step(1, 48'hC0_0001);
        chk("t3_s1_hold", m_axis_data_tdata, 48'hC0_0000);
        chk("t3_s1_tvalid", m_axis_data_tvalid, 1);
        chk("t3_s1_ramp", ramp, 0);
        chk("t3_s1_err", err_overrun, 1);
        step(1, 48'hC0_0002);
        chk("t3_s2_hold", m_axis_data_tdata, 48'hC0_0000);
        m_axis_data_tready = 1'b1;
        for (int s = 3; s < 8; s++) begin
            step(1, 48'hC0_0000 + 48'(s));
            chk("t3_tdata", m_axis_data_tdata, 48'hC0_0000 + 48'(s));
            chk("t3_ramp", ramp, 0);
        end
        step(1, 48'hC0_0008);
        chk("t3_s8_ramp", ramp, 1);
        chk("t3_s8_tdata", m_axis_data_tdata, 48'hC0_0008);
        chk("t3_sts", sts_data, 5);
        chk("t3_err_sticky", err_overrun, 1);

        // stall to k=5, disable with pending output, re-enable
        m_axis_data_tready = 1'b0;
        for (int s = 9; s < 13; s++) step(1, 48'hC0_0000 + 48'(s));
        chk("t4_pend_tdata", m_axis_data_tdata, 48'hC0_0008);
        cfg_data = mk_cfg(0, 0, 8'd0, 16'd8);
        step(0, 0);
        chk("t4_err_clr", err_overrun, 0);
        chk("t4_pend_tvalid", m_axis_data_tvalid, 1);
        chk("t4_pend_hold", m_axis_data_tdata, 48'hC0_0008);
        chk("t4_sts_held", sts_data, 5);
        m_axis_data_tready = 1'b1;
        step(0, 0);
        chk("t4_drained", m_axis_data_tvalid, 0);
        step(1, 48'hD0_0000);
        chk("t4_dis_no_load", m_axis_data_tvalid, 0);
        cfg_data = mk_cfg(1, 0, 8'd0, 16'd8);
        step(1, 48'hD0_0001);
        chk("t4_reen_ramp", ramp, 1);
        chk("t4_reen_tdata", m_axis_data_tdata, 48'hD0_0001);
        chk("t4_reen_sts", sts_data, 5);

        // asynchronous reset mid-sweep while holding a sample
        m_axis_data_tready = 1'b0;
        step(1, 48'hD0_0002);
        chk("t5_pre_err", err_overrun, 1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("t5_rst_tvalid", m_axis_data_tvalid, 0);
        chk("t5_rst_tdata", m_axis_data_tdata, 0);
        chk("t5_rst_err", err_overrun, 0);
        chk("t5_rst_sts", sts_data, 0);
        chk("t5_rst_ramp", ramp, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        m_axis_data_tready = 1'b1;
        step(0, 0);
        step(1, 48'hE0_0000);
        chk("t5_post_ramp", ramp, 1);
        chk("t5_post_tdata", m_axis_data_tdata, 48'hE0_0000);

        // P=0 behaves as P=1
        cfg_data = mk_cfg(0, 0, 8'd0, 16'd0);
        step(0, 0);
        cfg_data = mk_cfg(1, 0, 8'd0, 16'd0);
        for (int n = 1; n <= 3; n++) begin
            step(1, 48'hF0_0000 + 48'(n));
            chk("t6_ramp", ramp, 1);
            chk("t6_sts", sts_data, 16'(n));
        end

`ifdef FMCW_SRC_TEST_PATTERN_EN
        cfg_data = mk_cfg(0, 1, 8'd0, 16'd10);
        step(0, 0);
        cfg_data = mk_cfg(1, 1, 8'd0, 16'd10);
        for (int n = 0; n < 21; n++) begin
            logic [23:0] n24;
            n24 = 24'(n);
            step(1, 48'h5A5A_5A5A_5A5A);
            chk("t7_pat_tdata", m_axis_data_tdata, {n24, n24});
            chk("t7_pat_ramp", ramp, (n % 10 == 0) ? 1 : 0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
